// File: rtl/dpc_defect_inject.sv
// Dead-pixel defect injector: one-stage valid/ready raster pipe that overwrites LFSR-chosen interior pixels.
// Optional macro DPC_INJ_POS_EN adds registered out_x/out_y coordinate ports.
module dpc_defect_inject #(
  parameter int          H        = 1280,
  parameter int          V        = 720,
  parameter int          DENSITY  = 8,
  parameter int          MIN_GAP  = 4,
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter logic [23:0] HOT_VAL  = 24'hFFFFFF,
  parameter logic [23:0] COLD_VAL = 24'h000000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        inj_en,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] pixel_data_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] pixel_data_out,
  output logic        out_sof,
  output logic        out_eol,
  output logic        out_inj,
  output logic [15:0] frame_inj_cnt
`ifdef DPC_INJ_POS_EN
  ,
  output logic [15:0] out_x,
  output logic [15:0] out_y
`endif
);

  localparam logic [15:0] X_LAST = 16'(H - 1);
  localparam logic [15:0] Y_LAST = 16'(V - 1);
  localparam logic [15:0] X_HI   = 16'(H - 3);
  localparam logic [15:0] Y_HI   = 16'(V - 3);
  localparam logic [15:0] EDGE   = 16'd2;
  localparam logic [15:0] GAP_LD = 16'(MIN_GAP);
  localparam logic [8:0]  THRESH = 9'(DENSITY);

  // Fibonacci LFSR for x^16+x^14+x^13+x^11+1
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  logic [15:0] x_r, y_r, gap_r, lfsr_r, run_cnt_r;
  logic        frm_en_r;

  logic        acc_s, sof_pos_s, last_x_s, last_px_s, frm_en_s, interior_s, inj_s;
  logic [23:0] px_s;
  logic [15:0] run_inc_s;

  assign in_ready = ~out_valid | out_ready;

  // Per-pixel decode: position flags, inject decision and the value to load
  always_comb begin
    acc_s      = in_valid & in_ready;
    sof_pos_s  = (x_r == 16'd0) && (y_r == 16'd0);
    last_x_s   = (x_r == X_LAST);
    last_px_s  = last_x_s && (y_r == Y_LAST);
    frm_en_s   = sof_pos_s ? inj_en : frm_en_r;
    interior_s = (x_r >= EDGE) && (x_r <= X_HI) && (y_r >= EDGE) && (y_r <= Y_HI);
    inj_s      = frm_en_s & interior_s & (gap_r == 16'd0) & ({1'b0, lfsr_r[15:8]} < THRESH);
    px_s       = inj_s ? (lfsr_r[0] ? HOT_VAL : COLD_VAL) : pixel_data_in;
    run_inc_s  = (run_cnt_r == 16'hFFFF) ? run_cnt_r : (run_cnt_r + {15'd0, inj_s});
  end

  // Raster position, LFSR, spacing and injection counters; all advance only on accept
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_r           <= 16'd0;
      y_r           <= 16'd0;
      gap_r         <= 16'd0;
      lfsr_r        <= SEED;
      run_cnt_r     <= 16'd0;
      frm_en_r      <= 1'b0;
      frame_inj_cnt <= 16'd0;
    end else if (acc_s) begin
      frm_en_r <= frm_en_s;
      lfsr_r   <= lfsr_next(lfsr_r);
      if (last_x_s) begin
        x_r <= 16'd0;
        y_r <= (y_r == Y_LAST) ? 16'd0 : (y_r + 16'd1);
      end else begin
        x_r <= x_r + 16'd1;
      end
      // Gap is per-line: it never carries a spacing constraint into the next row
      if (last_x_s) begin
        gap_r <= 16'd0;
      end else if (inj_s) begin
        gap_r <= GAP_LD;
      end else if (gap_r != 16'd0) begin
        gap_r <= gap_r - 16'd1;
      end
      if (last_px_s) begin
        frame_inj_cnt <= run_inc_s;
        run_cnt_r     <= 16'd0;
      end else begin
        run_cnt_r <= run_inc_s;
      end
    end
  end

  // Output register: reload on accept (no bubble), drop valid only on a handshake without a new accept
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid      <= 1'b0;
      pixel_data_out <= 24'd0;
      out_sof        <= 1'b0;
      out_eol        <= 1'b0;
      out_inj        <= 1'b0;
`ifdef DPC_INJ_POS_EN
      out_x          <= 16'd0;
      out_y          <= 16'd0;
`endif
    end else if (acc_s) begin
      out_valid      <= 1'b1;
      pixel_data_out <= px_s;
      out_sof        <= sof_pos_s;
      out_eol        <= last_x_s;
      out_inj        <= inj_s;
`ifdef DPC_INJ_POS_EN
      out_x          <= x_r;
      out_y          <= y_r;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
